// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: multi-cycle FP32 multiplier, shift-add significand product,
// RNE rounding, denormals flushed to zero, valid/ready on both sides.
module fp32_mul_seq #(
   parameter int RADIX = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        invalid,
   output logic        busy
);

   localparam int         NCYC = 24 / RADIX;
   localparam logic [4:0] LAST = 5'(NCYC - 1);
   localparam logic [5:0] LRAD = 6'(RADIX);

   typedef enum logic [1:0] {
      S_IDLE, S_MULT, S_ROUND, S_DONE
   } state_t;

   state_t r_state, w_next;

   logic [23:0] r_ma, r_mb;
   logic [47:0] r_p;
   logic [4:0]  r_cnt;
   logic [9:0]  r_exp;
   logic        r_sign;
   logic [31:0] r_result;
   logic        r_ovf, r_unf, r_inv;

   logic w_acc, w_sign;
   logic w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic w_inv, w_inf, w_zero, w_spec;

   assign w_acc  = in_valid && in_ready;
   assign w_sign = a[31] ^ b[31];
   assign w_za   = (a[30:23] == 8'h00);
   assign w_zb   = (b[30:23] == 8'h00);
   assign w_ia   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
   assign w_ib   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
   assign w_na   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   assign w_nb   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   assign w_inv  = w_na | w_nb | (w_ia & w_zb) | (w_za & w_ib);
   assign w_inf  = w_ia | w_ib;
   assign w_zero = w_za | w_zb;
   assign w_spec = w_inv | w_inf | w_zero;

   // one multiplier digit per cycle, weighted by its position
   logic [RADIX-1:0] w_dig;
   logic [47:0]      w_pp, w_pacc;
   logic [5:0]       w_sh;

   assign w_dig  = r_mb[RADIX-1:0];
   assign w_pp   = 48'(r_ma) * 48'(w_dig);
   assign w_sh   = {1'b0, r_cnt} * LRAD;
   assign w_pacc = r_p + (w_pp << w_sh);

   logic        w_hi, w_g, w_r, w_s, w_inc;
   logic [22:0] w_m;
   logic [23:0] w_msum;
   logic [9:0]  w_e1;
   logic        w_ovf, w_unf;

   assign w_hi   = r_p[47];
   assign w_m    = w_hi ? r_p[46:24] : r_p[45:23];
   assign w_g    = w_hi ? r_p[23] : r_p[22];
   assign w_r    = w_hi ? r_p[22] : r_p[21];
   assign w_s    = w_hi ? |r_p[21:0] : |r_p[20:0];
   assign w_inc  = w_g & (w_r | w_s | w_m[0]);
   assign w_msum = {1'b0, w_m} + 24'(w_inc);
   assign w_e1   = r_exp + 10'(w_hi) + 10'(w_msum[23]);
   assign w_ovf  = $signed(w_e1) >= 10'sd255;
   assign w_unf  = $signed(w_e1) <= 10'sd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_acc) w_next = w_spec ? S_DONE : S_MULT;
         S_MULT:  if (r_cnt == LAST) w_next = S_ROUND;
         S_ROUND: w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ma     <= '0;
         r_mb     <= '0;
         r_p      <= '0;
         r_cnt    <= '0;
         r_exp    <= '0;
         r_sign   <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_inv    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_acc) begin
               r_sign <= w_sign;
               r_ma   <= {1'b1, a[22:0]};
               r_mb   <= {1'b1, b[22:0]};
               r_p    <= '0;
               r_cnt  <= '0;
               r_exp  <= {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
               if (w_spec) begin
                  r_ovf <= 1'b0;
                  r_unf <= 1'b0;
                  r_inv <= w_inv;
                  if (w_inv)      r_result <= 32'h7FC0_0000;
                  else if (w_inf) r_result <= {w_sign, 8'hFF, 23'd0};
                  else            r_result <= {w_sign, 31'd0};
               end
            end
            S_MULT: begin
               r_p   <= w_pacc;
               r_mb  <= r_mb >> RADIX;
               r_cnt <= r_cnt + 5'd1;
            end
            S_ROUND: begin
               r_ovf <= w_ovf;
               r_unf <= w_unf;
               r_inv <= 1'b0;
               if (w_ovf)      r_result <= {r_sign, 8'hFF, 23'd0};
               else if (w_unf) r_result <= {r_sign, 31'd0};
               else            r_result <= {r_sign, w_e1[7:0], w_msum[22:0]};
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign invalid   = r_inv;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb_fp32_mul_seq: scoreboard bench, integer reference model of IEEE RNE
// multiply with flush-to-zero, random operands and directed corner cases.
module tb_fp32_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, overflow, underflow, invalid, busy;
   logic [31:0] result;

   logic        iv4 = 1'b0, iv12 = 1'b0;
   logic        ir4, ov4, of4, uf4, nv4, bz4;
   logic        ir12, ov12, of12, uf12, nv12, bz12;
   logic [31:0] res4, res12;

   always #5 clk = ~clk;

   fp32_mul_seq #(.RADIX(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .overflow(overflow), .underflow(underflow),
      .invalid(invalid), .busy(busy));

   fp32_mul_seq #(.RADIX(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a), .b(b), .out_valid(ov4), .out_ready(1'b1),
      .result(res4), .overflow(of4), .underflow(uf4),
      .invalid(nv4), .busy(bz4));

   fp32_mul_seq #(.RADIX(12)) dut12 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12),
      .a(a), .b(b), .out_valid(ov12), .out_ready(1'b1),
      .result(res12), .overflow(of12), .underflow(uf12),
      .invalid(nv12), .busy(bz12));

   typedef struct {
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_chk = 0;
   int   cyc = 0;
   bit   force_hold = 1'b0;
   bit   rand_bp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      out_ready = force_hold ? 1'b0 : (rand_bp ? 1'($urandom % 2) : 1'b1);
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, expv);
   endtask

   // exact integer product, rounded to 24 significant bits (ties to even)
   function automatic exp_t model(logic [31:0] x, logic [31:0] y, int acc, int radix);
      exp_t   r;
      logic   s;
      int     ex, ey, e2, sh;
      bit     zx, zy, ix, iy, nx, ny;
      longint p, q, rem, half;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      zx = (ex == 0);
      zy = (ey == 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      r.acc = acc;
      r.fl  = 3'b000;
      r.lat = 1;
      if (nx || ny || (ix && zy) || (zx && iy)) begin
         r.res = 32'h7FC0_0000;
         r.fl  = 3'b001;
      end else if (ix || iy) begin
         r.res = {s, 8'hFF, 23'd0};
      end else if (zx || zy) begin
         r.res = {s, 31'd0};
      end else begin
         r.lat = 24 / radix + 2;
         p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
         sh = (p >= (64'sd1 <<< 47)) ? 24 : 23;
         e2 = ex + ey - 127 + (sh - 23);
         q    = p >>> sh;
         rem  = p - (q <<< sh);
         half = 64'sd1 <<< (sh - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (64'sd1 <<< 24)) begin
            q = 64'sd1 <<< 23;
            e2++;
         end
         if (e2 >= 255) begin
            r.res = {s, 8'hFF, 23'd0};
            r.fl  = 3'b100;
         end else if (e2 <= 0) begin
            r.res = {s, 31'd0};
            r.fl  = 3'b010;
         end else begin
            r.res = {s, 8'(e2), q[22:0]};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      int          k = $urandom_range(0, 15);
      logic        s = 1'($urandom);
      logic [22:0] f = 23'($urandom);
      logic [7:0]  e;
      case (k)
         0:       e = 8'h00;
         1:       begin e = 8'hFF; f = '0; end
         2:       begin e = 8'hFF; f[0] = 1'b1; end
         3:       e = 8'($urandom_range(200, 254));
         4:       e = 8'($urandom_range(1, 50));
         default: e = 8'($urandom_range(64, 190));
      endcase
      return {s, e, f};
   endfunction

   exp_t m;
   int   first;
   bit   seen = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else begin
         if (out_valid && !seen) begin
            seen  = 1'b1;
            first = cyc;
         end
         if (out_valid && out_ready) begin
            seen = 1'b0;
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL sb_extra actual=%h required=none", result);
            end else begin
               m = sb.pop_front();
               chk("result", result, m.res);
               chk("flags", {29'd0, overflow, underflow, invalid}, {29'd0, m.fl});
               chk("latency", 32'(first - m.acc + 1), 32'(m.lat));
            end
         end
      end
   end

   task automatic send(logic [31:0] x, logic [31:0] y);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_chk++;
         $display("FAIL send_timeout actual=%b required=1", in_ready);
         return;
      end
      a = x;
      b = y;
      in_valid = 1'b1;
      sb.push_back(model(x, y, cyc + 1, 1));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while ((sb.size() != 0 || !in_ready) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   logic [31:0] cap_res;
   logic [2:0]  cap_fl;
   int          acc, f4, f12;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {overflow, underflow, invalid}, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      send(32'h3F80_0000, 32'h3F80_0000);
      send(32'h3FC0_0000, 32'h3FC0_0000);
      send(32'h3F80_0001, 32'h3F80_0001);
      send(32'h3FFF_FFFF, 32'h3FFF_FFFF);
      send(32'h7F00_0000, 32'h7F00_0000);
      send(32'h0080_0000, 32'h0080_0000);
      send(32'h7F80_0000, 32'h0000_0000);
      send(32'hBFC0_0000, 32'h3FC0_0000);
      send(32'hFF80_0000, 32'h4000_0000);
      send(32'h8000_0000, 32'h4049_0FDB);
      send(32'h7FC0_1234, 32'h3F80_0000);
      send(32'h3F80_0001, 32'h3FFF_FFFF);
      drain();

      @(negedge clk);
      a = 32'h3FC0_0000;
      b = 32'h3FC0_0000;
      iv4 = 1'b1;
      iv12 = 1'b1;
      acc = cyc + 1;
      f4 = 0;
      f12 = 0;
      @(negedge clk);
      iv4 = 1'b0;
      iv12 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (ov4 && f4 == 0) f4 = cyc;
         if (ov12 && f12 == 0) f12 = cyc;
         @(negedge clk);
      end
      chk("r4_latency", 32'(f4 - acc + 1), 32'd8);
      chk("r12_latency", 32'(f12 - acc + 1), 32'd4);
      chk("r4_result", res4, 32'h4010_0000);
      chk("r12_result", res12, 32'h4010_0000);
      chk("r4_flags", {of4, uf4, nv4}, 0);
      chk("r12_flags", {of12, uf12, nv12}, 0);
      chk("r4_idle", {ir4, bz4}, 2'b10);
      chk("r12_idle", {ir12, bz12}, 2'b10);

      force_hold = 1'b1;
      send(32'h3FC0_0000, 32'h4000_0000);
      for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
      chk("hold_valid_seen", out_valid, 1);
      cap_res = result;
      cap_fl = {overflow, underflow, invalid};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_result", result, cap_res);
         chk("hold_flags", {overflow, underflow, invalid}, cap_fl);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_valid", out_valid, 1);
         if (k == 1) begin
            a = 32'h4080_0000;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      force_hold = 1'b0;
      drain();

      send(32'h3F80_0000, 32'h4040_0000);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h4000_0000, 32'h4040_0000);
      drain();

      rand_bp = 1'b1;
      repeat (80) send(rnd_op(), rnd_op());
      drain();
      rand_bp = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
